// File: rtl/serial_mag_comp_pkg.sv
// Shared types and sizing helpers for the serial magnitude comparator.
package serial_mag_comp_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Number of digits in an operand; a zero digit width is reported elsewhere.
  function automatic int unsigned calc_ndig(input int unsigned width, input int unsigned digit);
    return (digit == 0) ? 1 : (width / digit);
  endfunction

  // Width of a counter that can hold 0..NDIG.
  function automatic int unsigned calc_cnt_w(input int unsigned width, input int unsigned digit);
    return $clog2(calc_ndig(width, digit) + 1);
  endfunction

endpackage

// File: rtl/serial_mag_comp_if.sv
// Request/result bundle between a requester and the serial comparator.
interface serial_mag_comp_if
  import serial_mag_comp_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DIGIT = 4
);
  localparam int unsigned CNT_W = calc_cnt_w(WIDTH, DIGIT);

  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             signed_mode;
  logic             busy;
  logic             done;
  logic             gt;
  logic             lt;
  logic             eq;
  logic [CNT_W-1:0] ndig_used;

  modport master (
    output start, x, y, signed_mode,
    input  busy, done, gt, lt, eq, ndig_used
  );

  modport slave (
    input  start, x, y, signed_mode,
    output busy, done, gt, lt, eq, ndig_used
  );

endinterface

// File: rtl/serial_mag_comp_digit_comp.sv
// Unsigned combinational comparator for one digit.
module digit_comp #(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         g,
  output logic         l
);

  assign g = (a > b);
  assign l = (a < b);

endmodule

// File: rtl/serial_mag_comp.sv
// Multi-cycle MSB-first magnitude comparator, one DIGIT-bit slice per clock.
module serial_mag_comp
  import serial_mag_comp_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DIGIT      = 4,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_mag_comp_if.slave bus
);

  localparam int unsigned NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int unsigned CNT_W = calc_cnt_w(WIDTH, DIGIT);

  // Parameter sanity at elaboration.
  if (DIGIT < 1) begin : g_bad_digit
    $error("serial_mag_comp: DIGIT must be at least 1");
  end else if ((WIDTH % DIGIT) != 0) begin : g_bad_width
    $error("serial_mag_comp: WIDTH must be a multiple of DIGIT");
  end

  state_t           state;
  logic [WIDTH-1:0] x_sh;
  logic [WIDTH-1:0] y_sh;
  logic             smode;
  logic [CNT_W-1:0] cnt;
  logic             dec_gt;
  logic             dec_lt;

  logic dig_g, dig_l;
  logic sign_diff, step_gt, step_lt, fin_gt, fin_lt, finish;

  // The current digit is always the top slice of the shifting shadow registers.
  digit_comp #(.W(DIGIT)) u_digit (
    .a (x_sh[WIDTH-1 -: DIGIT]),
    .b (y_sh[WIDTH-1 -: DIGIT]),
    .g (dig_g),
    .l (dig_l)
  );

  // Per-digit decision; the first decision sticks when the scan runs to the end.
  always_comb begin
    sign_diff = smode && (cnt == '0) && (x_sh[WIDTH-1] != y_sh[WIDTH-1]);
    step_gt   = sign_diff ? ~x_sh[WIDTH-1] : dig_g;
    step_lt   = sign_diff ?  x_sh[WIDTH-1] : dig_l;
    fin_gt    = dec_gt || (!dec_lt && step_gt);
    fin_lt    = dec_lt || (!dec_gt && step_lt);
    finish    = (cnt == CNT_W'(NDIG - 1)) || ((EARLY_EXIT != 0) && (step_gt || step_lt));
  end

  // Control FSM, shadow registers and registered results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      x_sh          <= '0;
      y_sh          <= '0;
      smode         <= 1'b0;
      cnt           <= '0;
      dec_gt        <= 1'b0;
      dec_lt        <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.gt        <= 1'b0;
      bus.lt        <= 1'b0;
      bus.eq        <= 1'b0;
      bus.ndig_used <= '0;
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            x_sh          <= bus.x;
            y_sh          <= bus.y;
            smode         <= bus.signed_mode;
            cnt           <= '0;
            dec_gt        <= 1'b0;
            dec_lt        <= 1'b0;
            bus.gt        <= 1'b0;
            bus.lt        <= 1'b0;
            bus.eq        <= 1'b0;
            bus.ndig_used <= '0;
            bus.busy      <= 1'b1;
            state         <= RUN;
          end
        end
        RUN: begin
          if (finish) begin
            bus.gt        <= fin_gt;
            bus.lt        <= fin_lt;
            bus.eq        <= !fin_gt && !fin_lt;
            bus.ndig_used <= cnt + CNT_W'(1);
            bus.done      <= 1'b1;
            bus.busy      <= 1'b0;
            state         <= IDLE;
          end else begin
            dec_gt <= fin_gt;
            dec_lt <= fin_lt;
            cnt    <= cnt + CNT_W'(1);
            x_sh   <= x_sh << DIGIT;
            y_sh   <= y_sh << DIGIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench: early-exit and full-scan comparators against an arithmetic model.
module tb_serial_mag_comp;
  import serial_mag_comp_pkg::*;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DIGIT = 4;
  localparam int unsigned NDIG  = WIDTH / DIGIT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  serial_mag_comp_if #(.WIDTH(WIDTH), .DIGIT(DIGIT)) bus_e ();
  serial_mag_comp_if #(.WIDTH(WIDTH), .DIGIT(DIGIT)) bus_f ();

  serial_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(1)) dut_e (
    .clk(clk), .rst_n(rst_n), .bus(bus_e.slave)
  );
  serial_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT), .EARLY_EXIT(0)) dut_f (
    .clk(clk), .rst_n(rst_n), .bus(bus_f.slave)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic drive(input bit full, input logic st, input logic [15:0] xv,
                       input logic [15:0] yv, input logic sm);
    if (full) begin
      bus_f.start = st; bus_f.x = xv; bus_f.y = yv; bus_f.signed_mode = sm;
    end else begin
      bus_e.start = st; bus_e.x = xv; bus_e.y = yv; bus_e.signed_mode = sm;
    end
  endtask

  task automatic sample(input bit full, output logic bz, output logic dn, output logic g,
                        output logic l, output logic e, output logic [2:0] n);
    if (full) begin
      bz = bus_f.busy; dn = bus_f.done; g = bus_f.gt; l = bus_f.lt; e = bus_f.eq; n = bus_f.ndig_used;
    end else begin
      bz = bus_e.busy; dn = bus_e.done; g = bus_e.gt; l = bus_e.lt; e = bus_e.eq; n = bus_e.ndig_used;
    end
  endtask

  // Expected result from integer comparison; digit count from the highest differing bit.
  task automatic ref_model(input logic [15:0] xv, input logic [15:0] yv, input logic sm,
                           input bit full, output bit g, output bit l, output bit e, output int n);
    logic [15:0] d;
    int p;
    if (sm) begin
      g = $signed(xv) > $signed(yv);
      l = $signed(xv) < $signed(yv);
    end else begin
      g = xv > yv;
      l = xv < yv;
    end
    e = (xv == yv);
    d = xv ^ yv;
    p = -1;
    for (int b = 15; b >= 0; b--) begin
      if (d[b] && p < 0) p = b;
    end
    if (full || p < 0) n = NDIG;
    else if (sm && (xv[15] != yv[15])) n = 1;
    else n = NDIG - (p / DIGIT);
  endtask

  // One operation: accept, optional disturbance of inputs, bounded wait, result checks.
  task automatic do_op(input bit full, input logic [15:0] xv, input logic [15:0] yv,
                       input logic sm, input bit disturb, input string name);
    bit eg, el, ee;
    int en, lat;
    bit got;
    logic bz, dn, g, l, e;
    logic [2:0] n;
    ref_model(xv, yv, sm, full, eg, el, ee, en);
    @(negedge clk);
    drive(full, 1'b1, xv, yv, sm);
    @(posedge clk);
    @(negedge clk);
    if (disturb) drive(full, 1'b0, ~xv, 16'($urandom), ~sm);
    else drive(full, 1'b0, xv, yv, sm);
    sample(full, bz, dn, g, l, e, n);
    check({name, " busy_after_start"}, 32'(bz), 32'd1);
    check({name, " cleared_after_start"}, 32'({dn, g, l, e, n}), 32'd0);
    lat = 0;
    got = 0;
    while (lat < 20 && !got) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      sample(full, bz, dn, g, l, e, n);
      if (dn) got = 1;
      if (disturb && lat == 1 && !dn) begin
        if (full) bus_f.start = 1'b1; else bus_e.start = 1'b1;
      end else begin
        if (full) bus_f.start = 1'b0; else bus_e.start = 1'b0;
      end
    end
    check({name, " done_seen"}, 32'(got), 32'd1);
    check({name, " result"}, 32'({g, l, e}), 32'({eg, el, ee}));
    check({name, " ndig_used"}, 32'(n), 32'(en));
    check({name, " latency"}, 32'(lat), 32'(en));
    @(negedge clk);
    sample(full, bz, dn, g, l, e, n);
    check({name, " done_pulse_idle"}, 32'({bz, dn}), 32'd0);
    check({name, " result_held"}, 32'({g, l, e}), 32'({eg, el, ee}));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic bz, dn, g, l, e;
    logic [2:0] n;
    int lat, dones;
    bit got;

    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
    #1;
    sample(1'b0, bz, dn, g, l, e, n);
    check("reset_e", 32'({bz, dn, g, l, e, n}), 32'd0);
    sample(1'b1, bz, dn, g, l, e, n);
    check("reset_f", 32'({bz, dn, g, l, e, n}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed cases.
    do_op(1'b0, 16'h9000, 16'h1000, 1'b0, 1'b0, "uns_9000_1000");
    do_op(1'b0, 16'h9000, 16'h1000, 1'b1, 1'b0, "sgn_9000_1000");
    do_op(1'b0, 16'h1234, 16'h1235, 1'b0, 1'b0, "uns_1234_1235");
    do_op(1'b0, 16'hABCD, 16'hABCD, 1'b1, 1'b0, "eq_abcd");
    do_op(1'b1, 16'h8000, 16'h0FFF, 1'b0, 1'b0, "full_8000_0fff");
    do_op(1'b1, 16'h8000, 16'h0FFF, 1'b1, 1'b0, "full_sgn_8000_0fff");
    do_op(1'b1, 16'h0001, 16'h0000, 1'b0, 1'b0, "full_lsd_only");
    do_op(1'b0, 16'hFFFE, 16'hFFFF, 1'b1, 1'b1, "sgn_neg_disturb");
    do_op(1'b0, 16'h5555, 16'h5555, 1'b0, 1'b1, "eq_disturb");

    // Back-to-back: start held through the done cycle.
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h9000, 16'h1000, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h1234, 16'h1235, 1'b0);
    @(posedge clk);
    @(negedge clk);
    sample(1'b0, bz, dn, g, l, e, n);
    check("b2b first_done", 32'({bz, dn, g, l, e, n}), 32'({1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd1}));
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
    sample(1'b0, bz, dn, g, l, e, n);
    check("b2b second_accept", 32'({bz, dn, g, l, e, n}), 32'({1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0}));
    lat = 0;
    got = 0;
    while (lat < 20 && !got) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      sample(1'b0, bz, dn, g, l, e, n);
      if (dn) got = 1;
    end
    check("b2b second_done", 32'(got), 32'd1);
    check("b2b second_result", 32'({g, l, e, n}), 32'({1'b0, 1'b1, 1'b0, 3'd4}));
    check("b2b second_latency", 32'(lat), 32'd4);

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    drive(1'b0, 1'b1, 16'h5555, 16'h5555, 1'b0);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h5555, 16'h5555, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    sample(1'b0, bz, dn, g, l, e, n);
    check("midrun_reset", 32'({bz, dn, g, l, e, n}), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus_e.done || bus_e.busy) dones++;
    end
    check("no_done_after_reset", 32'(dones), 32'd0);
    do_op(1'b0, 16'h7000, 16'h7001, 1'b1, 1'b0, "after_reset");

    // Randomized operations on both variants.
    for (int i = 0; i < 60; i++) begin
      logic [15:0] xv, yv;
      logic sm;
      int mode;
      xv = 16'($urandom);
      sm = 1'($urandom);
      mode = $urandom_range(0, 3);
      case (mode)
        1: yv = xv;
        2: yv = xv ^ (16'd1 << $urandom_range(0, 15));
        default: yv = 16'($urandom);
      endcase
      do_op(1'(i % 2), xv, yv, sm, ($urandom_range(0, 3) == 0),
            $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
